// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage and windowed register file.
package wb_pkg;

    localparam int unsigned DATA_W       = 16;
    localparam int unsigned NUM_WIN      = 4;
    localparam int unsigned REGS_PER_WIN = 4;
    localparam int unsigned WIN_W        = 2;
    localparam int unsigned ADDR_W       = 2;
    localparam int unsigned PIDX_W       = WIN_W + ADDR_W;
    localparam int unsigned NUM_REGS     = NUM_WIN * REGS_PER_WIN;

    localparam logic [DATA_W-1:0] NOP_INST = 16'h8040;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'b00,
        WB_SEL_MEM  = 2'b01,
        WB_SEL_LINK = 2'b10,
        WB_SEL_LUI  = 2'b11
    } wb_sel_t;

    typedef logic [PIDX_W-1:0] phys_idx_t;

    // Physical register index: window in the upper bits, logical address below.
    function automatic phys_idx_t phys_idx(input logic [WIN_W-1:0] win,
                                           input logic [ADDR_W-1:0] addr);
        return {win, addr};
    endfunction

endpackage

// File: rtl/wb_regfile_stage_if.sv
// MEM/WB inputs, decode read ports and hazard-unit forwarding record.
interface wb_regfile_stage_if;
    import wb_pkg::*;

    logic [DATA_W-1:0] Inst;
    logic              RegWrite;
    logic [1:0]        RegData;
    logic [DATA_W-1:0] AluRes;
    logic [DATA_W-1:0] MemData;
    logic [DATA_W-1:0] Link;
    logic [WIN_W-1:0]  WindowW;
    logic [WIN_W-1:0]  RaWin;
    logic [WIN_W-1:0]  RbWin;
    logic [ADDR_W-1:0] RaAddr;
    logic [ADDR_W-1:0] RbAddr;
    logic [DATA_W-1:0] RaData;
    logic [DATA_W-1:0] RbData;
    logic              FwdValid;
    logic [PIDX_W-1:0] FwdDest;
    logic [DATA_W-1:0] FwdData;
    logic [DATA_W-1:0] RetireCount;

    modport master (
        output Inst, RegWrite, RegData, AluRes, MemData, Link, WindowW,
               RaWin, RbWin, RaAddr, RbAddr,
        input  RaData, RbData, FwdValid, FwdDest, FwdData, RetireCount
    );

    modport slave (
        input  Inst, RegWrite, RegData, AluRes, MemData, Link, WindowW,
               RaWin, RbWin, RaAddr, RbAddr,
        output RaData, RbData, FwdValid, FwdDest, FwdData, RetireCount
    );

endinterface

// File: rtl/windowed_regfile.sv
// 4-window x 4-register file, one write port, two combinational read ports.
// Logical register 0 of each window reads 0. Define WB_BYPASS_EN for
// same-cycle write-through to the read ports.
module windowed_regfile
    import wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  phys_idx_t         waddr,
    input  logic [DATA_W-1:0] wdata,
    input  phys_idx_t         ra_idx,
    input  phys_idx_t         rb_idx,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    // Array storage: cleared on reset, single write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port A: array, optional write-through, register 0 forced to zero.
    always_comb begin
        ra_data = mem[ra_idx];
`ifdef WB_BYPASS_EN
        if (we && (ra_idx == waddr)) ra_data = wdata;
`endif
        if (ra_idx[ADDR_W-1:0] == '0) ra_data = '0;
    end

    // Read port B: same rules as port A.
    always_comb begin
        rb_data = mem[rb_idx];
`ifdef WB_BYPASS_EN
        if (we && (rb_idx == waddr)) rb_data = wdata;
`endif
        if (rb_idx[ADDR_W-1:0] == '0) rb_data = '0;
    end

endmodule

// File: rtl/wb_regfile_stage.sv
// Writeback stage: value select, write qualification, retire counter and
// forwarding record around the windowed register file.
// Optional feature macro: WB_BYPASS_EN (same-cycle write-through on reads).
module wb_regfile_stage
    import wb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    wb_regfile_stage_if.slave bus
);

    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] wb_val;
    logic              is_nop;
    logic              we;
    phys_idx_t         wdest;

    assign rd     = bus.Inst[3:2];
    assign is_nop = (bus.Inst == NOP_INST);
    assign we     = bus.RegWrite & ~is_nop & (rd != '0) & ~rst;
    assign wdest  = phys_idx(bus.WindowW, rd);

    // Writeback value select.
    always_comb begin
        wb_val = bus.AluRes;
        case (wb_sel_t'(bus.RegData))
            WB_SEL_ALU:  wb_val = bus.AluRes;
            WB_SEL_MEM:  wb_val = bus.MemData;
            WB_SEL_LINK: wb_val = bus.Link;
            WB_SEL_LUI:  wb_val = {bus.Inst[11:4], 8'h00};
            default:     wb_val = bus.AluRes;
        endcase
    end

    windowed_regfile u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (wdest),
        .wdata   (wb_val),
        .ra_idx  (phys_idx(bus.RaWin, bus.RaAddr)),
        .rb_idx  (phys_idx(bus.RbWin, bus.RbAddr)),
        .ra_data (bus.RaData),
        .rb_data (bus.RbData)
    );

    // Forwarding record, latched on the same edge as the array write.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.FwdValid <= 1'b0;
            bus.FwdDest  <= '0;
            bus.FwdData  <= '0;
        end else begin
            bus.FwdValid <= we;
            bus.FwdDest  <= wdest;
            bus.FwdData  <= wb_val;
        end
    end

    // Retired non-NOP instruction counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.RetireCount <= '0;
        end else if (!is_nop) begin
            bus.RetireCount <= bus.RetireCount + DATA_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Self-checking bench for wb_regfile_stage: directed cases plus random
// traffic compared against an array-based reference model.
module tb_wb_regfile_stage;
    import wb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_regfile_stage_if bus ();

    wb_regfile_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [15:0] m_rf [16];
    logic [15:0] m_retire;
    logic        m_fv;
    logic [3:0]  m_fd;
    logic [15:0] m_fdat;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sel_value();
        case (bus.RegData)
            2'd0:    return bus.AluRes;
            2'd1:    return bus.MemData;
            2'd2:    return bus.Link;
            default: return {bus.Inst[11:4], 8'h00};
        endcase
    endfunction

    function automatic logic model_we();
        return bus.RegWrite && (bus.Inst != 16'h8040) && (bus.Inst[3:2] != 2'd0) && !rst;
    endfunction

    function automatic logic [15:0] exp_read(input logic [1:0] w, input logic [1:0] a);
        if (a == 2'd0) return 16'h0000;
`ifdef WB_BYPASS_EN
        if (model_we() && w == bus.WindowW && a == bus.Inst[3:2]) return sel_value();
`endif
        return m_rf[{w, a}];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_rf[i] = 16'h0000;
        m_retire = 16'h0000;
        m_fv     = 1'b0;
        m_fd     = 4'h0;
        m_fdat   = 16'h0000;
    endtask

    task automatic drive(input logic [15:0] inst, input logic rw, input logic [1:0] rsel,
                         input logic [15:0] alu, input logic [15:0] memd,
                         input logic [15:0] link, input logic [1:0] ww);
        bus.Inst     = inst;
        bus.RegWrite = rw;
        bus.RegData  = rsel;
        bus.AluRes   = alu;
        bus.MemData  = memd;
        bus.Link     = link;
        bus.WindowW  = ww;
    endtask

    // One cycle: check reads before the edge, advance model, check registered outputs.
    task automatic tick();
        logic [15:0] v;
        logic        wv;
        logic [3:0]  d;
        logic        r;
        logic [15:0] inst;
        #1;
        check_val("ra_read", bus.RaData, exp_read(bus.RaWin, bus.RaAddr));
        check_val("rb_read", bus.RbData, exp_read(bus.RbWin, bus.RbAddr));
        v    = sel_value();
        wv   = model_we();
        d    = {bus.WindowW, bus.Inst[3:2]};
        r    = rst;
        inst = bus.Inst;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (wv) m_rf[d] = v;
            m_fv   = wv;
            m_fd   = d;
            m_fdat = v;
            if (inst != 16'h8040) m_retire = m_retire + 16'd1;
        end
        #1;
        check_val("fwd_valid", {15'h0, bus.FwdValid}, {15'h0, m_fv});
        check_val("fwd_dest", {12'h0, bus.FwdDest}, {12'h0, m_fd});
        check_val("fwd_data", bus.FwdData, m_fdat);
        check_val("retire", bus.RetireCount, m_retire);
    endtask

    task automatic set_reads(input logic [1:0] aw, input logic [1:0] aa,
                             input logic [1:0] bw, input logic [1:0] ba);
        bus.RaWin  = aw;
        bus.RaAddr = aa;
        bus.RbWin  = bw;
        bus.RbAddr = ba;
    endtask

    logic [15:0] r0;

    initial begin
        rst = 1'b1;
        drive(16'h8040, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 2'd0);
        set_reads(2'd0, 2'd0, 2'd0, 2'd0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;

        // Reset state: every window/address reads zero
        for (int i = 0; i < 16; i++) begin
            set_reads(2'(i >> 2), 2'(i), 2'(i >> 2), 2'(i));
            #1;
            check_val("reset_read", bus.RaData, 16'h0000);
        end
        check_val("reset_retire", bus.RetireCount, 16'h0000);
        check_val("reset_fwd_valid", {15'h0, bus.FwdValid}, 16'h0000);

        // Writeback select coverage into W2 R3
        set_reads(2'd2, 2'd3, 2'd0, 2'd3);
        drive(16'h0A5C, 1'b1, 2'd0, 16'h1234, 16'hBEEF, 16'h0042, 2'd2);
        tick();
        check_val("sel_alu_read", bus.RaData, 16'h1234);
        check_val("sel_alu_fwd_valid", {15'h0, bus.FwdValid}, 16'h0001);
        check_val("sel_alu_fwd_dest", {12'h0, bus.FwdDest}, 16'h000B);
        check_val("sel_alu_fwd_data", bus.FwdData, 16'h1234);
        drive(16'h0A5C, 1'b1, 2'd1, 16'h1234, 16'hBEEF, 16'h0042, 2'd2);
        tick();
        check_val("sel_mem_read", bus.RaData, 16'hBEEF);
        drive(16'h0A5C, 1'b1, 2'd2, 16'h1234, 16'hBEEF, 16'h0042, 2'd2);
        tick();
        check_val("sel_link_read", bus.RaData, 16'h0042);
        drive(16'h0A5C, 1'b1, 2'd3, 16'h1234, 16'hBEEF, 16'h0042, 2'd2);
        tick();
        check_val("sel_lui_read", bus.RaData, 16'hA500);

        // NOP with RegWrite: no write, no retire
        r0 = bus.RetireCount;
        drive(16'h8040, 1'b1, 2'd0, 16'h7777, 16'h7777, 16'h7777, 2'd2);
        tick();
        check_val("nop_retire", bus.RetireCount, r0);
        check_val("nop_read", bus.RaData, 16'hA500);

        // Write to logical register 0 is dropped
        set_reads(2'd1, 2'd0, 2'd2, 2'd3);
        drive(16'h0010, 1'b1, 2'd0, 16'hFFFF, 16'h0, 16'h0, 2'd1);
        tick();
        check_val("r0_fwd_valid", {15'h0, bus.FwdValid}, 16'h0000);
        check_val("r0_read", bus.RaData, 16'h0000);

        // Same-cycle read/write of W1 R2; W0 R2 untouched
        drive(16'h0008, 1'b1, 2'd0, 16'h0001, 16'h0, 16'h0, 2'd1);
        tick();
        drive(16'h0008, 1'b1, 2'd0, 16'h5555, 16'h0, 16'h0, 2'd0);
        tick();
        set_reads(2'd1, 2'd2, 2'd0, 2'd2);
        drive(16'h0008, 1'b1, 2'd0, 16'h0F0F, 16'h0, 16'h0, 2'd1);
        #1;
`ifdef WB_BYPASS_EN
        check_val("same_cycle_ra", bus.RaData, 16'h0F0F);
`else
        check_val("same_cycle_ra", bus.RaData, 16'h0001);
`endif
        check_val("same_cycle_rb", bus.RbData, 16'h5555);
        tick();
        check_val("after_write_ra", bus.RaData, 16'h0F0F);
        check_val("after_write_rb", bus.RbData, 16'h5555);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(63) == 0);
            drive(($urandom_range(7) == 0) ? 16'h8040 : 16'($urandom),
                  1'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
                  16'($urandom), 2'($urandom));
            set_reads(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
            tick();
        end
        rst = 1'b0;

        // Reset during a valid write discards it
        set_reads(2'd3, 2'd1, 2'd2, 2'd3);
        drive(16'h0004, 1'b1, 2'd0, 16'hCAFE, 16'h0, 16'h0, 2'd3);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("midrst_read", bus.RaData, 16'h0000);
        check_val("midrst_fwd_valid", {15'h0, bus.FwdValid}, 16'h0000);
        check_val("midrst_fwd_dest", {12'h0, bus.FwdDest}, 16'h0000);
        check_val("midrst_fwd_data", bus.FwdData, 16'h0000);
        check_val("midrst_retire", bus.RetireCount, 16'h0000);

        // Retire counter wrap
        drive(16'h0001, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 2'd0);
        repeat (65535) @(posedge clk);
        #1;
        check_val("retire_max", bus.RetireCount, 16'hFFFF);
        @(posedge clk);
        #1;
        check_val("retire_wrap", bus.RetireCount, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
